fft_sequencer: RTL and testbench

Top-level control FSM for the 256-point FFT core. It steps the datapath through four phases: load input, butterfly compute, unload output, done. While doing so it drives the mode and counter inputs (`input_mode`, `samples_in_count`, `samples_out_count`, `iteration_count`, `stage_count`) of the sample-memory address generator. It also handshakes with the input streaming interface, the butterfly unit and the output streaming interface.

---
 rtl/fft_sequencer_if.sv | 20 ++
 rtl/fft_sequencer.sv | 157 +++++++++++++++
 tb/tb_fft_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sequencer_if.sv
// Handshake bundle between the FFT sequencer and its datapath neighbours:
// input stream, butterfly unit and output stream.
interface fft_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic bfly_start;
  logic bfly_done;
  logic out_valid;
  logic out_ready;

  modport master (
    input  in_valid, bfly_done, out_ready,
    output in_ready, bfly_start, out_valid
  );

  modport slave (
    input  in_ready, bfly_start, out_valid,
    output in_valid, bfly_done, out_ready
  );
endinterface

// File: rtl/fft_sequencer.sv
// Top-level control FSM for the 256-point FFT: load, butterfly compute,
// unload, done. Drives the address-generator mode and counters.
module fft_sequencer #(
  parameter int unsigned NUM_STAGES       = 8,
  parameter int unsigned NUM_ITERS        = 32,
  parameter int unsigned SAMPLES_PER_ITER = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  fft_sequencer_if.master    hs,
  output logic [1:0]         input_mode,
  output logic [3:0]         samples_in_count,
  output logic [3:0]         samples_out_count,
  output logic [4:0]         iteration_count,
  output logic [3:0]         stage_count,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] SAMP_LAST  = 4'(SAMPLES_PER_ITER - 1);
  localparam logic [4:0] ITER_LAST  = 5'(NUM_ITERS - 1);
  localparam logic [3:0] STAGE_LAST = 4'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_UNLOAD, S_FIN
  } state_t;

  state_t     state, state_n;
  logic [3:0] sin_n, sout_n, stage_n;
  logic [4:0] iter_n;
  logic [1:0] mode_n;

  always_comb begin
    state_n = state;
    sin_n   = samples_in_count;
    sout_n  = samples_out_count;
    iter_n  = iteration_count;
    stage_n = stage_count;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          sin_n   = '0;
          sout_n  = '0;
          iter_n  = '0;
          stage_n = '0;
        end
      end
      S_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a transfer
        if (hs.in_valid) begin
          if (samples_in_count == SAMP_LAST) begin
            sin_n = '0;
            if (iteration_count == ITER_LAST) begin
              iter_n  = '0;
              state_n = S_ISSUE;
            end else begin
              iter_n = iteration_count + 5'd1;
            end
          end else begin
            sin_n = samples_in_count + 4'd1;
          end
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (hs.bfly_done) begin
          if (iteration_count != ITER_LAST) begin
            iter_n  = iteration_count + 5'd1;
            state_n = S_ISSUE;
          end else if (stage_count != STAGE_LAST) begin
            iter_n  = '0;
            stage_n = stage_count + 4'd1;
            state_n = S_ISSUE;
          end else begin
            iter_n  = '0;
            stage_n = '0;
            state_n = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        if (hs.out_ready) begin
          if (samples_out_count == SAMP_LAST) begin
            sout_n = '0;
            if (iteration_count == ITER_LAST) begin
              iter_n  = '0;
              state_n = S_FIN;
            end else begin
              iter_n = iteration_count + 5'd1;
            end
          end else begin
            sout_n = samples_out_count + 4'd1;
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
        sin_n   = '0;
        sout_n  = '0;
        iter_n  = '0;
        stage_n = '0;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n = S_IDLE;
      sin_n   = '0;
      sout_n  = '0;
      iter_n  = '0;
      stage_n = '0;
    end
  end

  always_comb begin
    mode_n = 2'b00;
    unique case (state_n)
      S_LOAD:          mode_n = 2'b01;
      S_ISSUE, S_WAIT: mode_n = 2'b10;
      S_UNLOAD:        mode_n = 2'b11;
      default:         mode_n = 2'b00;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      samples_in_count  <= '0;
      samples_out_count <= '0;
      iteration_count   <= '0;
      stage_count       <= '0;
      input_mode        <= '0;
      hs.in_ready       <= 1'b0;
      hs.bfly_start     <= 1'b0;
      hs.out_valid      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_n;
      samples_in_count  <= sin_n;
      samples_out_count <= sout_n;
      iteration_count   <= iter_n;
      stage_count       <= stage_n;
      input_mode        <= mode_n;
      hs.in_ready       <= (state_n == S_LOAD);
      hs.bfly_start     <= (state_n == S_ISSUE);
      hs.out_valid      <= (state_n == S_UNLOAD);
      busy              <= (state_n != S_IDLE);
      done              <= (state_n == S_FIN);
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: IDLE decision table, reset mid-load,
// full FFT runs with scoreboarded load/unload counters, and abort recovery.
module tb_fft_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] input_mode;
  logic [3:0] samples_in_count, samples_out_count, stage_count;
  logic [4:0] iteration_count;
  logic       busy, done;

  fft_sequencer_if bus ();

  fft_sequencer #(
    .NUM_STAGES(8),
    .NUM_ITERS(32),
    .SAMPLES_PER_ITER(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .hs(bus),
    .input_mode(input_mode),
    .samples_in_count(samples_in_count),
    .samples_out_count(samples_out_count),
    .iteration_count(iteration_count),
    .stage_count(stage_count),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] it;
    logic [3:0] sc;
    logic       dn;
  } exp_t;

  typedef struct {
    logic       st, ab, bd;
    logic [1:0] mode;
    logic       bsy, rdy;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_fft();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_mode", input_mode, 1);
    chk("start_in_ready", bus.in_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic do_load(input bit toggle);
    int   k = 0;
    exp_t e, g;
    for (int c = 0; c < 600 && k < 256; c++) begin
      bus.in_valid = toggle ? (c % 2 == 0) : 1'b1;
      chk("load_in_ready", bus.in_ready, 1);
      if (bus.in_valid) k++;
      e.mode = (k == 256) ? 2'b10 : 2'b01;
      e.it   = 5'((k % 256) / 8);
      e.sc   = 4'(k % 8);
      e.dn   = 1'b0;
      sb.push_back(e);
      step();
      g = sb.pop_front();
      chk("load_mode", input_mode, g.mode);
      chk("load_iter", iteration_count, g.it);
      chk("load_sin", samples_in_count, g.sc);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_compute(input int dly, input int poke_at, input int abort_at,
                            output bit aborted);
    aborted = 1'b0;
    for (int p = 0; p < 256; p++) begin
      chk("bfly_start", bus.bfly_start, 1);
      chk("cmp_mode", input_mode, 2);
      chk("cmp_stage", stage_count, p / 32);
      chk("cmp_iter", iteration_count, p % 32);
      bus.bfly_done = 1'b0;
      step();
      for (int w = 1; w < dly; w++) begin
        chk("wait_no_start", bus.bfly_start, 0);
        if (p == poke_at && w == 1) start = 1'b1;
        step();
        start = 1'b0;
      end
      if (p == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        aborted = 1'b1;
        return;
      end
      bus.bfly_done = 1'b1;
      step();
      bus.bfly_done = 1'b0;
    end
    chk("unload_mode", input_mode, 3);
    chk("unload_out_valid", bus.out_valid, 1);
    chk("unload_no_bfly", bus.bfly_start, 0);
    chk("unload_stage0", stage_count, 0);
  endtask

  task automatic do_unload(output int t_done);
    exp_t e, g;
    for (int k = 1; k <= 256; k++) begin
      chk("unload_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      e.mode = (k == 256) ? 2'b00 : 2'b11;
      e.it   = 5'((k % 256) / 8);
      e.sc   = 4'(k % 8);
      e.dn   = (k == 256);
      sb.push_back(e);
      step();
      g = sb.pop_front();
      chk("unload_mode_sb", input_mode, g.mode);
      chk("unload_iter", iteration_count, g.it);
      chk("unload_sout", samples_out_count, g.sc);
      chk("unload_done", done, g.dn);
    end
    bus.out_ready = 1'b0;
    t_done = cyc;
    chk("fin_busy", busy, 1);
    step();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_mode", input_mode, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   ab;
    int   t0, td;

    vt[0] = '{st: 0, ab: 0, bd: 0, mode: 2'b00, bsy: 0, rdy: 0};
    vt[1] = '{st: 1, ab: 1, bd: 0, mode: 2'b00, bsy: 0, rdy: 0};
    vt[2] = '{st: 0, ab: 0, bd: 1, mode: 2'b00, bsy: 0, rdy: 0};
    vt[3] = '{st: 1, ab: 0, bd: 0, mode: 2'b01, bsy: 1, rdy: 1};
    vt[4] = '{st: 1, ab: 0, bd: 1, mode: 2'b01, bsy: 1, rdy: 1};
    vt[5] = '{st: 0, ab: 1, bd: 1, mode: 2'b00, bsy: 0, rdy: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.bfly_done = 1'b0; bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_mode", input_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_bfly_start", bus.bfly_start, 0);
    chk("rst_iter", iteration_count, 0);
    rst = 1'b0;

    // IDLE decision table; abort returns to IDLE between vectors
    for (int i = 0; i < 6; i++) begin
      start = vt[i].st; abort = vt[i].ab; bus.bfly_done = vt[i].bd;
      step();
      start = 1'b0; abort = 1'b0; bus.bfly_done = 1'b0;
      chk("tbl_mode", input_mode, vt[i].mode);
      chk("tbl_busy", busy, vt[i].bsy);
      chk("tbl_in_ready", bus.in_ready, vt[i].rdy);
      chk("tbl_sin", samples_in_count, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("tbl_back_idle", input_mode, 0);
    end

    // reset in the middle of LOAD at iteration 5 / sample 3
    start_fft();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 43; i++) step();
    chk("midload_iter", iteration_count, 5);
    chk("midload_sin", samples_in_count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_mode", input_mode, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_iter", iteration_count, 0);
    chk("midrst_sin", samples_in_count, 0);
    chk("midrst_busy", busy, 0);

    // toggling in_valid, slow butterfly, stray start during compute
    start_fft();
    do_load(1'b1);
    do_compute(3, 10, -1, ab);
    do_unload(td);

    // minimum-latency run
    t0 = cyc;
    start_fft();
    do_load(1'b0);
    chk("issue_latency", cyc - t0, 257);
    do_compute(1, -1, -1, ab);
    do_unload(td);
    chk("done_latency", td - t0, 1025);

    // abort at stage 4 / iteration 17 while waiting on the butterfly
    start_fft();
    do_load(1'b0);
    do_compute(2, -1, 4 * 32 + 17, ab);
    chk("abort_mode", input_mode, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stage", stage_count, 0);
    chk("abort_iter", iteration_count, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      bus.bfly_done = 1'b1;
      step();
      chk("stray_done", done, 0);
      chk("stray_mode", input_mode, 0);
      chk("stray_bfly", bus.bfly_start, 0);
    end
    bus.bfly_done = 1'b0;

    start_fft();
    do_load(1'b0);
    do_compute(1, -1, -1, ab);
    do_unload(td);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
